// File: rtl/data_sram_bridge_pkg.sv
// Shared types and constants for the data-side SRAM bridge.
package data_sram_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/data_size_enc.sv
// Encodes store byte strobes or load size into the bus transfer size.
module data_size_enc
  import data_sram_bridge_pkg::*;
(
  input  logic       memwrite,
  input  logic [3:0] sig_write,
  input  logic [1:0] load_size,
  output logic [1:0] size
);

  // Stores derive size from the strobe pattern; loads pass load_size with 3 folded to word.
  always_comb begin
    size = SZ_WORD;
    if (memwrite) begin
      unique case (sig_write)
        4'b1111:                            size = SZ_WORD;
        4'b0011, 4'b1100:                   size = SZ_HALF;
        4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SZ_BYTE;
        default:                            size = SZ_WORD;
      endcase
    end else begin
      size = (load_size == 2'd3) ? SZ_WORD : load_size;
    end
  end

endmodule

// File: rtl/data_sram_bridge.sv
// Bridges the single-cycle memory-stage interface onto a split-transaction SRAM-like bus.
module data_sram_bridge
  import data_sram_bridge_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          memenM,
  input  logic          memwriteM,
  input  logic [3:0]    sig_write,
  input  logic [1:0]    load_size,
  input  logic [AW-1:0] aluoutM,
  input  logic [DW-1:0] writedataM,
  input  logic          stall_other,
  output logic [DW-1:0] readdataM,
  output logic          stall_mem,
  output logic          data_req,
  output logic          data_wr,
  output logic [1:0]    data_size,
  output logic [AW-1:0] data_addr,
  output logic [DW-1:0] data_wdata,
  input  logic          data_addr_ok,
  input  logic          data_data_ok,
  input  logic [DW-1:0] data_rdata
);

  state_t        state, state_nxt;
  logic          wr_q;
  logic [1:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic [1:0]    size_enc;
  logic          finish;

  data_size_enc u_size_enc (
    .memwrite  (memwriteM),
    .sig_write (sig_write),
    .load_size (load_size),
    .size      (size_enc)
  );

  // Data phase completes either alongside acceptance in REQ or later in WAIT.
  assign finish = data_data_ok & (((state == REQ) & data_addr_ok) | (state == WAIT));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (memenM) state_nxt = REQ;
      REQ: begin
        if (data_addr_ok & data_data_ok) state_nxt = DONE;
        else if (data_addr_ok)           state_nxt = WAIT;
      end
      WAIT: if (data_data_ok) state_nxt = DONE;
      DONE: if (!stall_other) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured once at issue so the bus never sees datapath changes mid-transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if ((state == IDLE) && memenM) begin
      wr_q    <= memwriteM;
      size_q  <= size_enc;
      addr_q  <= aluoutM;
      wdata_q <= writedataM;
    end
  end

  // Load data is held until the next load completes; strays outside REQ/WAIT are ignored.
  always_ff @(posedge clk) begin
    if (rst)                rdata_q <= '0;
    else if (finish && !wr_q) rdata_q <= data_rdata;
  end

  assign stall_mem  = memenM & (state != DONE);
  assign data_req   = (state == REQ);
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;
  assign readdataM  = rdata_q;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Self-checking bench for data_sram_bridge using a transaction timeline model.
module tb_data_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        memenM, memwriteM;
  logic [3:0]  sig_write;
  logic [1:0]  load_size;
  logic [31:0] aluoutM, writedataM;
  logic        stall_other;
  logic [31:0] readdataM;
  logic        stall_mem;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] exp_rd  = '0;

  data_sram_bridge #(.AW(32), .DW(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .memenM       (memenM),
    .memwriteM    (memwriteM),
    .sig_write    (sig_write),
    .load_size    (load_size),
    .aluoutM      (aluoutM),
    .writedataM   (writedataM),
    .stall_other  (stall_other),
    .readdataM    (readdataM),
    .stall_mem    (stall_mem),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Bus size expected for a store, from how many and which strobes are set.
  function automatic logic [1:0] store_size(input logic [3:0] sw);
    case ($countones(sw))
      1:       return 2'd0;
      2:       return (sw == 4'b0011 || sw == 4'b1100) ? 2'd1 : 2'd2;
      default: return 2'd2;
    endcase
  endfunction

  // One access: cycle 0 is the issuing IDLE cycle, addr_ok comes a cycles after the
  // first request cycle, data_ok d cycles after that, then h extra held DONE cycles.
  task automatic access(input logic wr, input logic [3:0] sw, input logic [1:0] ls,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int a, input int d,
                        input int h, input bit flush);
    int t_done = 2 + a + d;
    int t_end  = t_done + h;
    logic [1:0] sz = wr ? store_size(sw) : ((ls == 2'd3) ? 2'd2 : ls);
    bit req_exp;
    for (int k = 0; k <= t_end; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        memenM = 1'b1; memwriteM = wr; sig_write = sw; load_size = ls;
        aluoutM = addr; writedataM = wdata;
      end else begin
        memenM     = flush ? 1'($urandom_range(0, 1)) : 1'b1;
        memwriteM  = 1'($urandom);
        sig_write  = 4'($urandom);
        load_size  = 2'($urandom);
        aluoutM    = $urandom;
        writedataM = $urandom;
      end
      data_addr_ok = (k == 1 + a);
      data_data_ok = (k == t_done - 1) || (k >= t_done && $urandom_range(0, 1) == 1) ||
                     (k == 0 && $urandom_range(0, 1) == 1);
      data_rdata   = (k == t_done - 1) ? rdata : $urandom;
      stall_other  = (k >= t_done) ? (k < t_end) : 1'($urandom_range(0, 1));
      #1;
      if (k == t_done && !wr) exp_rd = rdata;
      req_exp = (k >= 1) && (k <= 1 + a);
      chk("data_req", 32'(data_req), 32'(req_exp));
      if (req_exp) begin
        chk("data_addr",  data_addr,        addr);
        chk("data_wr",    32'(data_wr),     32'(wr));
        chk("data_size",  32'(data_size),   32'(sz));
        chk("data_wdata", data_wdata,       wdata);
      end
      chk("stall_mem", 32'(stall_mem), 32'(memenM && (k < t_done)));
      chk("readdataM", readdataM, exp_rd);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      memenM = 1'b0; data_addr_ok = 1'b0;
      data_data_ok = 1'($urandom_range(0, 1)); data_rdata = $urandom;
      stall_other = 1'($urandom_range(0, 1));
      #1;
      chk("idle_req",   32'(data_req),  32'd0);
      chk("idle_stall", 32'(stall_mem), 32'd0);
      chk("idle_rd",    readdataM,      exp_rd);
    end
  endtask

  // Reset mid-transaction: in WAIT after addr_ok, or in REQ before it.
  task automatic rst_mid(input int a, input bit in_wait);
    int t_rst = in_wait ? 2 + a : 1;
    for (int k = 0; k <= t_rst; k++) begin
      @(posedge clk); #1;
      memenM = 1'b1; memwriteM = 1'b0; sig_write = 4'h0; load_size = 2'd2;
      aluoutM = 32'h8000_0040; writedataM = 32'h1234_5678;
      data_addr_ok = in_wait && (k == 1 + a);
      data_data_ok = 1'b0; stall_other = 1'b0;
      rst = (k == t_rst);
      #1;
      chk("rm_req", 32'(data_req), 32'((k >= 1) && (k <= (in_wait ? 1 + a : t_rst))));
    end
    @(posedge clk); #1;
    rst = 1'b0; memenM = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hBAD0_BAD0;
    exp_rd = '0;
    #1;
    chk("rm_req_after",  32'(data_req),  32'd0);
    chk("rm_addr_after", data_addr,      32'd0);
    chk("rm_rd_after",   readdataM,      32'd0);
    chk("rm_stall",      32'(stall_mem), 32'd0);
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    #1;
    chk("rm_late_ok_rd", readdataM,     32'd0);
    chk("rm_late_req",   32'(data_req), 32'd0);
  endtask

  initial begin
    rst = 1'b1; memenM = 1'b0; memwriteM = 1'b0; sig_write = '0; load_size = '0;
    aluoutM = '0; writedataM = '0; stall_other = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    @(posedge clk); #1;
    memenM = 1'b1;
    #1;
    chk("rst_req",   32'(data_req),   32'd0);
    chk("rst_wr",    32'(data_wr),    32'd0);
    chk("rst_size",  32'(data_size),  32'd0);
    chk("rst_addr",  data_addr,       32'd0);
    chk("rst_wdata", data_wdata,      32'd0);
    chk("rst_rd",    readdataM,       32'd0);
    chk("rst_stall", 32'(stall_mem),  32'd1);
    @(posedge clk); #1;
    rst = 1'b0; memenM = 1'b0;

    access(1'b0, 4'h0, 2'd2, 32'h8000_1004, 32'h0, 32'hDEAD_BEEF, 0, 1, 0, 1'b0);
    idle(1);
    access(1'b1, 4'b0100, 2'd0, 32'h8000_0002, 32'h00AB_0000, 32'h5555_5555, 0, 0, 0, 1'b0);
    idle(1);
    access(1'b0, 4'h0, 2'd1, 32'h8000_0100, 32'h0, 32'hCAFE_F00D, 3, 2, 0, 1'b0);
    access(1'b0, 4'h0, 2'd0, 32'h8000_0201, 32'h0, 32'h0000_00A5, 0, 0, 4, 1'b0);
    idle(2);
    access(1'b0, 4'h0, 2'd2, 32'h8000_0300, 32'h0, 32'h1111_1111, 0, 0, 0, 1'b0);
    access(1'b0, 4'h0, 2'd3, 32'h8000_0304, 32'h0, 32'h2222_2222, 0, 0, 0, 1'b0);
    access(1'b1, 4'b1100, 2'd0, 32'h8000_0402, 32'hBEEF_0000, 32'h0, 1, 1, 1, 1'b1);
    access(1'b1, 4'b0110, 2'd0, 32'h8000_0404, 32'h00FF_FF00, 32'h0, 0, 2, 0, 1'b0);

    rst_mid(2, 1'b1);
    rst_mid(1, 1'b0);

    for (int i = 0; i < 150; i++) begin
      access(1'($urandom), 4'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_sram_bridge.md
# data_sram_bridge

- Converts the datapath's single-cycle memory-stage interface (enable, write, byte strobes, address, write data, read data) into a split-transaction SRAM-like handshake bus.
- Sits directly downstream of the datapath's memory stage, between it and the data-side bus.
- While a transaction is outstanding it asserts a stall to the hazard unit.
- It holds the returned read data stable until the pipeline advances.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- memenM  in  1  memory access valid in memory stage
- memwriteM  in  1  1 = store, 0 = load
- sig_write  in  4  store byte strobes from write-data alignment
- load_size  in  2  load size: 0 = byte, 1 = half, 2 = word
- aluoutM  in  AW  effective address
- writedataM  in  DW  aligned store data
- stall_other  in  1  pipeline held by another source this cycle
- readdataM  out  DW  captured load data
- stall_mem  out  1  memory stage not yet complete
- data_req  out  1  bus request
- data_wr  out  1  bus write
- data_size  out  2  bus size
- data_addr  out  AW  bus address
- data_wdata  out  DW  bus write data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  data phase complete; also the write acknowledge
- data_rdata  in  DW  read data, valid with data_data_ok

## Operation
FSM states and transitions:
- IDLE: if memenM, latch wr/size/addr/wdata from inputs; go to REQ.
- REQ: data_req = 1, latched fields driven.
  - On data_addr_ok & data_data_ok in the same cycle: go to DONE.
  - On data_addr_ok alone: go to WAIT.
  - Otherwise stay in REQ.
- WAIT: data_req = 0. On data_data_ok, go to DONE.
- DONE: transaction finished.
  - If ~stall_other, go to IDLE.
  - Otherwise stay in DONE; no re-issue.

Read data capture:
- On data_data_ok for a load, capture data_rdata into readdataM.
- Stores leave readdataM unchanged.

Output equations:
- stall_mem = memenM & (state != DONE). This is combinational.
- Bus outputs come only from latched registers, never directly from datapath inputs.

Store size from sig_write:
- 1111 → 2
- 0011 or 1100 → 1
- 0001, 0010, 0100, 1000 → 0
- any other pattern → 2

Loads use load_size directly. load_size = 3 is treated as 2.

data_addr is passed unmodified, including the low bits. Alignment faults are handled upstream.

## Timing
- Reset values:
  - state IDLE
  - data_req 0, data_wr 0, data_size 0, data_addr 0, data_wdata 0
  - readdataM 0
  - stall_mem = memenM (combinational)
- Minimum access, memenM asserted at cycle 0:
  - Cycle 1: REQ. addr_ok and data_ok arrive in this same cycle.
  - Cycle 2: DONE. stall_mem low; readdataM valid.
- Each cycle of addr_ok or data_ok delay adds one cycle of stall.
- Back-to-back accesses: DONE → IDLE → REQ. There is one idle cycle between bus requests.
- data_req stays high continuously from REQ entry until addr_ok. Address, size, wr and wdata stay stable across that window.
- data_data_ok seen in IDLE or DONE is ignored and does not corrupt readdataM.
- rst in REQ or WAIT: return to IDLE next cycle and drop data_req. The bus slave shares the reset, so the outstanding transaction is abandoned.
- memenM deasserted while in REQ or WAIT (pipeline flush): the transaction still completes to DONE. DONE then exits on ~stall_other.

## Structure
- Shared package holds:
  - the state enum (IDLE, REQ, WAIT, DONE)
  - the size constants SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2
- Optional sub-module data_size_enc: combinational encoding of sig_write/load_size into the bus size.
- Everything else stays in one module.

## Test plan
- Load word: addr 0x80001004, load_size 2. addr_ok in cycle 1, data_ok in cycle 2 with rdata 0xDEADBEEF → data_req high only in cycle 1; readdataM = 0xDEADBEEF; stall_mem falls in cycle 3.
- Store byte: sig_write 0100, addr 0x80000002, wdata 0x00AB0000 → data_wr 1, data_size 0, data_wdata 0x00AB0000; readdataM unchanged.
- Wait states: addr_ok delayed 3 cycles, data_ok delayed 2 more → data_req and address stable throughout; stall_mem high until the DONE cycle.
- stall_other held 4 cycles in DONE → no new data_req; readdataM held; IDLE entered the cycle after stall_other drops.
- rst asserted while in WAIT → next cycle state IDLE, data_req 0, readdataM 0; a late data_ok is ignored.
- Two consecutive loads returning 0x11111111 then 0x22222222 → two requests separated by exactly one idle cycle; readdataM updates in order.
